// File: rtl/serial_to_parallel_pkg.sv
// Shared types and constants for the serial-to-parallel converter.
package serial_to_parallel_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Bit-count register width: enough to hold the value w without wrapping.
    function automatic int unsigned cnt_bits(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_to_parallel.sv
// Assembles MSB-first serial frames into WIDTH-bit words with a one-deep output buffer.
module serial_to_parallel
    import serial_to_parallel_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             S_START,
    input  logic             S_VALID,
    input  logic             S_IN,
    input  logic             P_READY,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] P_OUT,
    output logic             P_VALID,
    output logic             OVERRUN,
    output logic             FRAME_ERR,
    output logic             BUSY
);

    localparam int unsigned CW = cnt_bits(WIDTH);

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic [WIDTH-1:0] first_bit;
    logic             word_done;

    always_comb begin
        shift_nxt = {shift_reg[WIDTH-2:0], S_IN};
        first_bit = WIDTH'(S_IN);
        word_done = (state == SHIFT) && S_VALID && !S_START && (bit_cnt == CW'(WIDTH - 1));
    end

    assign BUSY = (state == SHIFT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            P_OUT     <= '0;
            P_VALID   <= 1'b0;
            OVERRUN   <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            // Clear first so a same-cycle error event below wins.
            if (CLR_ERR) begin
                OVERRUN   <= 1'b0;
                FRAME_ERR <= 1'b0;
            end

            if (word_done) begin
                if (!P_VALID || P_READY) begin
                    P_OUT   <= shift_nxt;
                    P_VALID <= 1'b1;
                end else begin
                    OVERRUN <= 1'b1;
                end
            end else if (P_VALID && P_READY) begin
                P_VALID <= 1'b0;
            end

            if (S_VALID) begin
                unique case (state)
                    IDLE: begin
                        if (S_START) begin
                            shift_reg <= first_bit;
                            bit_cnt   <= CW'(1);
                            state     <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (S_START) begin
                            FRAME_ERR <= 1'b1;
                            shift_reg <= first_bit;
                            bit_cnt   <= CW'(1);
                        end else begin
                            shift_reg <= shift_nxt;
                            if (word_done) begin
                                bit_cnt <= '0;
                                state   <= IDLE;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench: stimulus pushes expected words, a monitor pops them on each handshake.
module tb_serial_to_parallel;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        S_START;
    logic        S_VALID;
    logic        S_IN;
    logic        P_READY;
    logic        CLR_ERR;
    logic [31:0] P_OUT;
    logic        P_VALID;
    logic        OVERRUN;
    logic        FRAME_ERR;
    logic        BUSY;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    logic [31:0] sb[$];

    serial_to_parallel #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .S_START   (S_START),
        .S_VALID   (S_VALID),
        .S_IN      (S_IN),
        .P_READY   (P_READY),
        .CLR_ERR   (CLR_ERR),
        .P_OUT     (P_OUT),
        .P_VALID   (P_VALID),
        .OVERRUN   (OVERRUN),
        .FRAME_ERR (FRAME_ERR),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Sends the first nbits of w MSB first; gap idle cycles follow every bit.
    task automatic send_word(input logic [31:0] w, input int gap, input int nbits,
                             input bit clr_on_start, input bit rdy_last);
        for (int i = 0; i < nbits; i++) begin
            S_VALID = 1'b1;
            S_START = (i == 0);
            S_IN    = w[31-i];
            CLR_ERR = clr_on_start && (i == 0);
            if (rdy_last && i == nbits - 1) P_READY = 1'b1;
            cyc();
            S_VALID = 1'b0;
            S_START = 1'b0;
            CLR_ERR = 1'b0;
            for (int g = 0; g < gap; g++) cyc();
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                if (BUSY) busy_cnt++;
                if (P_VALID && P_READY) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %h expected none", P_OUT);
                    end else begin
                        chk("sb_word", P_OUT, sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        RESET = 1'b1; S_START = 1'b0; S_VALID = 1'b0; S_IN = 1'b0;
        P_READY = 1'b0; CLR_ERR = 1'b0;
        repeat (3) cyc();
        chk("rst_p_out", P_OUT, 32'h0);
        chk("rst_p_valid", 32'(P_VALID), 32'h0);
        chk("rst_overrun", 32'(OVERRUN), 32'h0);
        chk("rst_frame_err", 32'(FRAME_ERR), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        RESET = 1'b0;
        cyc();

        // Contiguous frame, one-cycle latency and one-cycle valid pulse.
        P_READY = 1'b1;
        sb.push_back(32'hA5C3_0F96);
        send_word(32'hA5C3_0F96, 0, 32, 1'b0, 1'b0);
        chk("latency_valid", 32'(P_VALID), 32'h1);
        chk("latency_word", P_OUT, 32'hA5C3_0F96);
        chk("busy_after", 32'(BUSY), 32'h0);
        cyc();
        chk("valid_pulse", 32'(P_VALID), 32'h0);

        // Gapped frame: BUSY spans from the first to the last sampled bit.
        busy_cnt = 0;
        sb.push_back(32'hA5C3_0F96);
        send_word(32'hA5C3_0F96, 1, 32, 1'b0, 1'b0);
        chk("busy_cycles", 32'(busy_cnt), 32'd62);

        // Overrun: second word dropped while the first is unconsumed.
        P_READY = 1'b0;
        sb.push_back(32'h1234_5678);
        send_word(32'h1234_5678, 0, 32, 1'b0, 1'b0);
        send_word(32'hFFFF_0000, 0, 32, 1'b0, 1'b0);
        chk("ovr_word_kept", P_OUT, 32'h1234_5678);
        chk("ovr_flag", 32'(OVERRUN), 32'h1);
        chk("ovr_valid", 32'(P_VALID), 32'h1);
        CLR_ERR = 1'b1;
        cyc();
        CLR_ERR = 1'b0;
        chk("ovr_cleared", 32'(OVERRUN), 32'h0);
        P_READY = 1'b1;
        cyc();
        chk("ovr_drained", 32'(P_VALID), 32'h0);

        // Restart at bit 10; CLR_ERR on the restarting bit loses to the error.
        sb.push_back(32'h0000_0001);
        send_word(32'hFFFF_FFFF, 0, 10, 1'b0, 1'b0);
        chk("busy_mid", 32'(BUSY), 32'h1);
        send_word(32'h0000_0001, 0, 32, 1'b1, 1'b0);
        chk("ferr_flag", 32'(FRAME_ERR), 32'h1);
        chk("ferr_word", P_OUT, 32'h0000_0001);
        cyc();

        // Reset mid-frame overrides a valid start bit and clears everything.
        send_word(32'hCAFE_BABE, 0, 20, 1'b0, 1'b0);
        RESET = 1'b1; S_VALID = 1'b1; S_START = 1'b1; S_IN = 1'b1;
        cyc();
        chk("mid_rst_p_out", P_OUT, 32'h0);
        chk("mid_rst_valid", 32'(P_VALID), 32'h0);
        chk("mid_rst_ferr", 32'(FRAME_ERR), 32'h0);
        chk("mid_rst_ovr", 32'(OVERRUN), 32'h0);
        chk("mid_rst_busy", 32'(BUSY), 32'h0);
        RESET = 1'b0; S_VALID = 1'b0; S_START = 1'b0;
        cyc();
        sb.push_back(32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF, 0, 32, 1'b0, 1'b0);
        chk("post_rst_word", P_OUT, 32'hDEAD_BEEF);
        chk("post_rst_ferr", 32'(FRAME_ERR), 32'h0);
        cyc();

        // Completion in the same cycle the held word is accepted.
        P_READY = 1'b0;
        sb.push_back(32'h1111_2222);
        sb.push_back(32'h3333_4444);
        send_word(32'h1111_2222, 0, 32, 1'b0, 1'b0);
        send_word(32'h3333_4444, 0, 32, 1'b0, 1'b1);
        chk("same_cyc_valid", 32'(P_VALID), 32'h1);
        chk("same_cyc_word", P_OUT, 32'h3333_4444);
        chk("same_cyc_ovr", 32'(OVERRUN), 32'h0);
        cyc();
        chk("same_cyc_drain", 32'(P_VALID), 32'h0);

        repeat (3) cyc();
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
